// File: rtl/sram_ctrl_ws.sv
//======================================================================
// Module   : sram_ctrl_ws
// Async-SRAM controller with a req/rsp handshake and programmable
// read/write wait states. Define SRAM_TURNAROUND_EN to add one idle
// bus-turnaround cycle after every write.
// Revision : 1.0
//======================================================================
`default_nettype none

module sram_ctrl_ws #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 20,
    parameter int BE_W    = DATA_W / 8,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    input  logic [BE_W-1:0]   REQ_BE_N,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              BUSY,
    inout  wire  [DATA_W-1:0] SRAM_DATA,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic [BE_W-1:0]   SRAM_BE_N
);

    localparam int c_MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int c_CNT_W    = $clog2(c_MAX_WAIT + 2);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4
`ifdef SRAM_TURNAROUND_EN
        ,
        ST_TURN     = 3'd5
`endif
    } state_t;

    state_t              r_state;
    logic                r_ready;
    logic                r_busy;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_ce_n;
    logic                r_oe_n;
    logic                r_we_n;
    logic [BE_W-1:0]     r_be_n;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_drive;
    logic [c_CNT_W-1:0]  r_cnt;

    // Drive enable is registered alongside the strobes so OE_N low and a
    // driven bus are both decided on the same edge and cannot overlap.
    assign SRAM_DATA = r_drive ? r_wdata : {DATA_W{1'bz}};

    assign REQ_READY = r_ready;
    assign BUSY      = r_busy;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_RDATA = r_rsp_rdata;
    assign SRAM_ADDR = r_addr;
    assign SRAM_CE_N = r_ce_n;
    assign SRAM_OE_N = r_oe_n;
    assign SRAM_WE_N = r_we_n;
    assign SRAM_BE_N = r_be_n;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_be_n      <= '1;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_drive     <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (REQ_VALID && r_ready) begin
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_addr  <= REQ_ADDR;
                        r_be_n  <= REQ_BE_N;
                        r_ce_n  <= 1'b0;
                        if (REQ_WE) begin
                            r_wdata <= REQ_WDATA;
                            r_drive <= 1'b1;
                            r_state <= ST_WR_SETUP;
                        end else begin
                            r_oe_n  <= 1'b0;
                            r_cnt   <= c_CNT_W'(RD_WAIT);
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (r_cnt == '0) begin
                        r_rsp_rdata <= SRAM_DATA;
                        r_rsp_valid <= 1'b1;
                        r_ce_n      <= 1'b1;
                        r_oe_n      <= 1'b1;
                        r_be_n      <= '1;
                        r_ready     <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WR_SETUP: begin
                    r_we_n  <= 1'b0;
                    r_cnt   <= c_CNT_W'(WR_WAIT - 1);
                    r_state <= ST_WR_PULSE;
                end
                ST_WR_PULSE: begin
                    if (r_cnt == '0) begin
                        r_we_n  <= 1'b1;
                        r_state <= ST_WR_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_WR_HOLD: begin
                    r_drive <= 1'b0;
                    r_ce_n  <= 1'b1;
                    r_be_n  <= '1;
`ifdef SRAM_TURNAROUND_EN
                    r_state <= ST_TURN;
`else
                    r_rsp_valid <= 1'b1;
                    r_ready     <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
`endif
                end
`ifdef SRAM_TURNAROUND_EN
                ST_TURN: begin
                    r_rsp_valid <= 1'b1;
                    r_ready     <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
`endif
                default: begin
                    r_drive <= 1'b0;
                    r_ce_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                    r_we_n  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_ctrl_ws.sv
//======================================================================
// Module   : tb_sram_ctrl_ws
// Bench for sram_ctrl_ws: cycle-schedule reference model plus directed
// latency/data checks; follows SRAM_TURNAROUND_EN if defined.
// Revision : 1.0
//======================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sram_ctrl_ws;

    localparam int DW  = 32;
    localparam int AW  = 20;
    localparam int BW  = 4;
    localparam int RDW = 1;
    localparam int WRW = 2;
`ifdef SRAM_TURNAROUND_EN
    localparam int TRN = 1;
`else
    localparam int TRN = 0;
`endif

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [BW-1:0] req_be_n = '1;
    wire           req_ready, rsp_valid, busy, ce_n, oe_n, we_n;
    wire  [DW-1:0] rsp_rdata;
    wire  [AW-1:0] sram_addr;
    wire  [BW-1:0] be_n;
    tri   [DW-1:0] sram_data;

    // second instance: RD_WAIT=0, WR_WAIT=1
    logic          v0 = 1'b0;
    logic          w0 = 1'b0;
    wire           rdy0, rv0, busy0, ce0, oe0, we0n;
    wire  [DW-1:0] rd0;
    wire  [AW-1:0] ao0;
    wire  [BW-1:0] beo0;
    tri   [DW-1:0] bus0;

    sram_ctrl_ws #(.DATA_W(DW), .ADDR_W(AW), .BE_W(BW), .RD_WAIT(RDW), .WR_WAIT(WRW)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_WE(req_we), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_BE_N(req_be_n),
        .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .BUSY(busy), .SRAM_DATA(sram_data),
        .SRAM_ADDR(sram_addr), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
        .SRAM_BE_N(be_n)
    );

    sram_ctrl_ws #(.DATA_W(DW), .ADDR_W(AW), .BE_W(BW), .RD_WAIT(0), .WR_WAIT(1)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N), .REQ_VALID(v0), .REQ_READY(rdy0),
        .REQ_WE(w0), .REQ_ADDR(20'h00005), .REQ_WDATA(32'hCAFE0001), .REQ_BE_N(4'b0000),
        .RSP_VALID(rv0), .RSP_RDATA(rd0), .BUSY(busy0), .SRAM_DATA(bus0),
        .SRAM_ADDR(ao0), .SRAM_CE_N(ce0), .SRAM_OE_N(oe0), .SRAM_WE_N(we0n),
        .SRAM_BE_N(beo0)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 3)       return 32'hAAAAAAAA;
        else if (a == 16) return 32'hDEADBEEF;
        else              return {12'h5C3, a[19:0]};
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int i = 0; i < BW; i++)
            if (!be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // ---------------- SRAM chip model ----------------
    logic [DW-1:0] mem [int];
    logic [DW-1:0] sram_q = '0;
    logic          ce_prev = 1'b1;
    int            n_access = 0;

    assign sram_data = (!ce_n && !oe_n && we_n) ? sram_q : {DW{1'bz}};
    assign bus0      = (!ce0 && !oe0) ? 32'h0BADF00D : {DW{1'bz}};

    always @(negedge CLK) begin
        int a;
        a = int'(sram_addr);
        if (!ce_n && !we_n)
            mem[a] = merge(mem.exists(a) ? mem[a] : init_word(a), sram_data, be_n);
        sram_q = mem.exists(a) ? mem[a] : init_word(a);
        if (!ce_n && ce_prev) n_access++;
        ce_prev = ce_n;
    end

    // ---------------- reference model: per-cycle expected schedule ----------------
    typedef struct packed {
        logic          ce, oe, we, drv;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] wd;
    } pins_t;

    pins_t         sched [int];
    logic          rsp_isrd [int];
    logic [DW-1:0] rsp_data [int];
    logic [DW-1:0] refm [int];
    int            cyc = 0;
    int            busy_end = -1;
    bit            armed = 1'b0;
    int            acc_cnt = 0;
    int            last_acc = 0;
    logic [DW-1:0] held = '0;

    always @(posedge CLK or negedge RST_N) begin
        int a, ka;
        if (!RST_N) begin
            armed    = 1'b0;
            busy_end = -1;
            sched.delete();
            rsp_isrd.delete();
            rsp_data.delete();
        end else begin
            if (armed && cyc > busy_end && req_valid) begin
                a  = cyc + 1;
                ka = int'(req_addr);
                if (!req_we) begin
                    for (int k = 0; k <= RDW; k++)
                        sched[a+k] = {1'b0, 1'b0, 1'b1, 1'b0, req_addr, req_be_n, {DW{1'b0}}};
                    rsp_isrd[a+RDW+1] = 1'b1;
                    rsp_data[a+RDW+1] = refm.exists(ka) ? refm[ka] : init_word(ka);
                    busy_end = a + RDW;
                end else begin
                    for (int k = 0; k <= WRW + 1; k++)
                        sched[a+k] = {1'b0, 1'b1, (k >= 1 && k <= WRW) ? 1'b0 : 1'b1, 1'b1,
                                      req_addr, req_be_n, req_wdata};
                    rsp_isrd[a+WRW+2+TRN] = 1'b0;
                    refm[ka] = merge(refm.exists(ka) ? refm[ka] : init_word(ka), req_wdata, req_be_n);
                    busy_end = a + WRW + 1 + TRN;
                end
                acc_cnt++;
                last_acc = a;
            end
            armed = 1'b1;
            cyc   = cyc + 1;
        end
    end

    always @(negedge CLK) begin
        pins_t e;
        int    p;
        p = cyc;
        e = {1'b1, 1'b1, 1'b1, 1'b0, {AW{1'b0}}, {BW{1'b1}}, {DW{1'b0}}};
        if (RST_N && sched.exists(p)) e = sched[p];
        if (!RST_N) held = '0;
        else if (rsp_isrd.exists(p) && rsp_isrd[p]) held = rsp_data[p];
        chk("strobes", {ce_n, oe_n, we_n}, {e.ce, e.oe, e.we});
        if (!e.ce) chk("addr_be", {sram_addr, be_n}, {e.addr, e.be});
        if (e.drv) chk("bus_wdata", sram_data, e.wd);
        chk("req_ready", req_ready, RST_N && armed && p > busy_end);
        chk("busy", busy, RST_N && p <= busy_end);
        chk("rsp_valid", rsp_valid, RST_N && rsp_isrd.exists(p));
        chk("rsp_rdata", rsp_rdata, held);
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] b);
        req_valid = 1'b1;
        req_we    = w;
        req_addr  = a;
        req_wdata = d;
        req_be_n  = b;
    endtask

    task automatic wait_acc(output int a);
        int n0, t;
        n0 = acc_cnt;
        t  = 0;
        while (acc_cnt == n0 && t < 40) begin
            @(posedge CLK); #1;
            t++;
        end
        if (acc_cnt == n0) chk("accept_timeout", 0, 1);
        a = last_acc;
    endtask

    task automatic settle();
        repeat (8) begin @(posedge CLK); #1; end
    endtask

    // lat/first/last counted with the first access cycle as cycle 1
    task automatic meas(input bit wr, output int lat, output int lo_first, output int lo_last);
        int c;
        c = 1; lat = -1; lo_first = -1; lo_last = -1;
        while (c < 30 && lat < 0) begin
            @(negedge CLK);
            if ((wr ? we_n : oe_n) == 1'b0) begin
                if (lo_first < 0) lo_first = c;
                lo_last = c;
            end
            if (rsp_valid) lat = c;
            @(posedge CLK); #1;
            c++;
        end
        if (lat < 0) chk("rsp_timeout", 0, 1);
    endtask

    task automatic dut0_op(input bit wr, output int lat, output int lo_cnt);
        int t, c;
        v0 = 1'b1; w0 = wr; t = 0;
        while (!rdy0 && t < 20) begin @(posedge CLK); #1; t++; end
        @(posedge CLK); #1;
        v0 = 1'b0;
        c = 1; lat = -1; lo_cnt = 0;
        while (c < 20 && lat < 0) begin
            @(negedge CLK);
            if (c == 1) chk("d0_busy_addr", {busy0, ao0, beo0}, {1'b1, 20'h00005, 4'b0000});
            if ((wr ? we0n : oe0) == 1'b0) lo_cnt++;
            if (rv0) lat = c;
            @(posedge CLK); #1;
            c++;
        end
    endtask

    initial begin
        int a1, a2, lat, f, l, n0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        chk("ready_after_release", req_ready, 1'b1);

        // reset in the middle of the write pulse
        drive(1'b1, 20'h007FF, 32'h55555555, 4'b0000);
        wait_acc(a1);
        req_valid = 1'b0;
        @(posedge CLK); #2;
        chk("pulse_we_low", we_n, 1'b0);
        RST_N = 1'b0;
        #1;
        chk("rst_strobes", {ce_n, oe_n, we_n}, 3'b111);
        chk("rst_flags", {rsp_valid, req_ready, busy}, 3'b000);
        @(negedge CLK); #2;
        RST_N = 1'b1;
        chk("ready_before_edge", req_ready, 1'b0);
        @(posedge CLK); #1;
        chk("ready_after_rst", req_ready, 1'b1);

        // read 0x10
        drive(1'b0, 20'h00010, '0, 4'b0000);
        wait_acc(a1);
        req_valid = 1'b0;
        meas(1'b0, lat, f, l);
        chk("rd_lat", lat, 3);
        chk("rd_oe_window", {f[7:0], l[7:0]}, 16'h0102);
        chk("rd_data", rsp_rdata, 32'hDEADBEEF);

        // partial write 0x3, then read back
        drive(1'b1, 20'h00003, 32'h12345678, 4'b1100);
        wait_acc(a1);
        req_valid = 1'b0;
        meas(1'b1, lat, f, l);
        chk("wr_lat", lat, 5 + TRN);
        chk("wr_we_window", {f[7:0], l[7:0]}, 16'h0203);
        chk("wr_keeps_rdata", rsp_rdata, 32'hDEADBEEF);
        settle();
        drive(1'b0, 20'h00003, '0, 4'b0000);
        wait_acc(a1);
        req_valid = 1'b0;
        meas(1'b0, lat, f, l);
        chk("readback_merge", rsp_rdata, 32'hAAAA5678);

        // write then read back-to-back
        drive(1'b1, 20'h00020, 32'h11223344, 4'b0000);
        wait_acc(a1);
        drive(1'b0, 20'h00020, '0, 4'b0000);
        wait_acc(a2);
        req_valid = 1'b0;
        chk("wr_rd_spacing", a2 - a1, 5 + TRN);
        settle();
        chk("wr_rd_data", rsp_rdata, 32'h11223344);

        // request held through a busy read
        n0 = n_access;
        drive(1'b0, 20'h00010, '0, 4'b0000);
        wait_acc(a1);
        drive(1'b0, 20'h00003, '0, 4'b0000);
        wait_acc(a2);
        req_valid = 1'b0;
        chk("rd_rd_spacing", a2 - a1, 3);
        settle();
        chk("two_accesses", n_access - n0, 2);

        // random traffic against the reference model
        for (int i = 0; i < 100; i++) begin
            drive(1'($urandom_range(0, 1)), 20'h00100 + 20'($urandom_range(0, 15)),
                  $urandom, 4'($urandom_range(0, 15)));
            wait_acc(a1);
            if ($urandom_range(0, 2) != 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
            end
        end
        req_valid = 1'b0;
        settle();

        // zero-wait-state read, single-cycle write pulse
        dut0_op(1'b0, lat, f);
        chk("d0_rd_lat", lat, 2);
        chk("d0_oe_cycles", f, 1);
        chk("d0_rd_data", rd0, 32'h0BADF00D);
        dut0_op(1'b1, lat, f);
        chk("d0_wr_lat", lat, 4 + TRN);
        chk("d0_we_cycles", f, 1);
        chk("d0_wr_keeps_rdata", rd0, 32'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
